muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide unit for the pipelined MIPS core.
- Executes mult, multu, div and divu, which the ALU decoder leaves undefined. Owns the HI/LO architectural registers and services mthi/mtlo/mfhi/mflo.
- Sits beside the ALU in the EX stage. Raises stall to the hazard unit while an operation is in flight.
- Sequences a shift-add multiplier and a restoring divider with one FSM and an iteration counter.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNTW, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  EX-stage mult/div instruction valid.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- srca  in  WIDTH  rs operand.
- srcb  in  WIDTH  rt operand.
- wr_hi  in  1  mthi valid in EX.
- wr_lo  in  1  mtlo valid in EX.
- wdata  in  WIDTH  mthi/mtlo data.
- rd_hilo  in  1  mfhi/mflo valid in EX.
- busy  out  1  operation in flight (state != IDLE).
- stall  out  1  pipeline hold request.
- done  out  1  one-cycle pulse when HI/LO receive a result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset: state=IDLE, hi=0, lo=0, count=0, done=0, busy=0. Reset in any state aborts the operation and discards partial results.
- FSM states: IDLE -> ITER -> FIX -> IDLE.
- IDLE:
  - start=1 at edge E0 latches |srca|, |srcb| and the op.
  - Signed ops take absolute values: neg_q=a[31]^b[31], neg_r=a[31]. Unsigned ops clear both.
  - Sets count=0 and goes to ITER.
- ITER, edges E1..E32, one iteration per edge:
  - Multiply: 2*WIDTH product accumulator, shift-add on multiplier LSB.
  - Divide: restoring; shift remainder left, trial-subtract divisor, set quotient bit if non-negative.
  - Goes to FIX when count==WIDTH-1; otherwise count++.
- FIX, edge E33:
  - Applies two's-complement negation.
  - Multiply: negates the full 64-bit product if neg_q. Writes hi=product[63:32], lo=product[31:0].
  - Divide: lo=quotient (negated if neg_q), hi=remainder (negated if neg_r).
  - Goes to IDLE with done=1 for exactly the following cycle.
- Fixed latency: busy is high for the 33 cycles after E0. Results are visible the cycle after E33. Latency is independent of operand values.
- Divide by zero: same latency, lo=all ones, hi=srca (raw, unsigned view). Deterministic by decision.
- Signed overflow, div 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the algorithm with no special case.
- mthi/mtlo:
  - Honoured only in IDLE; take effect on that edge.
  - wr_hi and wr_lo in the same cycle write both registers.
  - When start and wr_hi/wr_lo coincide in IDLE, start wins and the writes are dropped. Decoder guarantees exclusivity, so this is a safety rule only.
- stall = busy & (start | rd_hilo | wr_hi | wr_lo). The stalled instruction re-presents its request each cycle.
  - start while busy is ignored; operands are not relatched.
  - In the done cycle, state is IDLE and busy=0. A waiting mfhi/mflo reads the new hi/lo without stall, and a new start is accepted on that edge.
- hi/lo never change except at FIX, an IDLE mthi/mtlo, or reset.

Decomposition:
- Shared package muldiv_pkg holds:
  - the op enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - the state enum (ST_IDLE, ST_ITER, ST_FIX);
  - the WIDTH default.
- Sub-module muldiv_dp holds the accumulator/remainder/quotient registers, the iteration step and the sign fix. It is driven by the load, step and fix strobes from muldiv_ctrl.
- muldiv_ctrl keeps the FSM, the counter, stall/done and the HI/LO registers.

Test Plan:
- mult: srca=0xFFFFFFFE (-2), srcb=0x00000003 -> busy for 33 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu: srca=0xFFFFFFFF, srcb=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, latency matching the mult case.
- div: srca=0xFFFFFFF9 (-7), srcb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 -> lo=0xFFFFFFFF, hi=0x00000007.
- Hazard: rd_hilo held from cycle 1 after start -> stall=1 every busy cycle. In the done cycle stall=0 and hi/lo already hold the result. A second start in cycle 5 is ignored and raises stall.
- Synchronous reset at cycle 10 of a div -> next cycle busy=0, hi=lo=0, done never pulses. A following mthi 0x1234 in IDLE -> hi=0x1234 next cycle.
- Signed overflow div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Back-to-back start issued in the done cycle is accepted -> busy again the next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  // op encoding as presented by the EX stage
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_dp.sv
// Datapath: shared accumulator for shift-add multiply and restoring divide,
// plus the final sign fix. acc holds {product_hi, product_lo} for multiply
// and {remainder, dividend/quotient} for divide.
import muldiv_pkg::*;

module muldiv_dp #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;   // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div0;

  logic               sgn;
  logic               ld_div;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     rsh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // Operand magnitudes and one iteration of each algorithm
  always_comb begin
    sgn    = (op == MD_MULT) || (op == MD_DIV);
    ld_div = (op == MD_DIV) || (op == MD_DIVU);
    abs_a  = (sgn && srca[WIDTH-1]) ? -srca : srca;
    abs_b  = (sgn && srcb[WIDTH-1]) ? -srcb : srcb;
    // multiply: add multiplicand into the top half on multiplier LSB, shift right
    msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {msum, acc[WIDTH-1:1]};
    // divide: shift next dividend bit into remainder, trial subtract;
    // diff MSB set means the subtraction went negative (restore)
    rsh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = rsh - {1'b0, opnd};
    if (!diff[WIDTH])
      div_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_next = {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Working registers: captured on load, advanced on each step
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else if (load) begin
      is_div <= ld_div;
      neg_q  <= sgn & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
      neg_r  <= sgn & srca[WIDTH-1];
      div0   <= (srcb == '0);
      if (ld_div) begin
        acc  <= {{WIDTH{1'b0}}, abs_a};
        opnd <= abs_b;
      end else begin
        acc  <= {{WIDTH{1'b0}}, abs_b};
        opnd <= abs_a;
      end
    end else if (step) begin
      acc <= is_div ? div_next : mul_next;
    end
  end

  // Sign fix; outputs are zero outside fix so partial values never leak.
  // Divide by zero keeps the all-ones quotient unnegated; the remainder
  // path already reproduces the raw dividend.
  always_comb begin
    prod   = neg_q ? -acc : acc;
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    res_hi = '0;
    res_lo = '0;
    if (fix) begin
      if (is_div) begin
        res_lo = div0 ? '1 : (neg_q ? -quo : quo);
        res_hi = neg_r ? -rem : rem;
      end else begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle mult/div unit control: FSM, iteration counter, HI/LO,
// stall and done.
//
// Request/hold semantics: an EX-stage request (start, rd_hilo, wr_hi,
// wr_lo) is taken on a rising edge only when stall is low; while stall is
// high the pipeline holds and re-presents the same request every cycle,
// and starts seen while busy are ignored (operands are not relatched).
import muldiv_pkg::*;

module muldiv_ctrl #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_hilo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output md_state_e        dbg_state
);

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  md_state_e        state_q;
  md_state_e        state_d;
  logic [CNTW-1:0]  count;
  logic             load;
  logic             step;
  logic             fix;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  muldiv_dp #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .fix    (fix),
    .op     (md_op_e'(op)),
    .srca   (srca),
    .srcb   (srcb),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // Next-state and datapath strobes
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        step = 1'b1;
        if (count == LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        fix     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, iteration counter and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= fix;
      if (load)
        count <= '0;
      else if (step && count != LAST)
        count <= count + 1'b1;
    end
  end

  // HI/LO: written by a finished operation or by mthi/mtlo in IDLE;
  // a coincident start takes priority over the moves
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (fix) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (state_q == ST_IDLE && !start) begin
      if (wr_hi) hi <= wdata;
      if (wr_lo) lo <= wdata;
    end
  end

  // Status outputs
  always_comb begin
    busy      = (state_q != ST_IDLE);
    stall     = busy & (start | rd_hilo | wr_hi | wr_lo);
    dbg_state = state_q;
  end

endmodule
